// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: assembles a 32-bit little-endian instruction
// from four byte reads of a ROM with BYTE_LAT cycles of read latency.
module inst_fetch_unit #(
    parameter int BYTE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        busy_o,
    output logic        mem_ce_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t              state;
    logic [31:0]         base;
    logic [1:0]          icnt;
    logic [1:0]          rcnt;
    logic [BYTE_LAT-1:0] pipe;
    logic [31:0]         pc_al;

    assign busy_o = (state != IDLE);
    assign pc_al  = {pc_i[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            base         <= '0;
            icnt         <= '0;
            rcnt         <= '0;
            pipe         <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            mem_ce_o     <= 1'b0;
            mem_addr_o   <= '0;
        end else if (flush_i) begin
            // In-flight returns are dropped by clearing the pipe
            state        <= IDLE;
            inst_valid_o <= 1'b0;
            mem_ce_o     <= 1'b0;
            pipe         <= '0;
        end else begin
            pipe[0] <= mem_ce_o;
            for (int i = 1; i < BYTE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        state      <= FETCH;
                        base       <= pc_al;
                        mem_ce_o   <= 1'b1;
                        mem_addr_o <= pc_al;
                        icnt       <= '0;
                        rcnt       <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ce_o) begin
                        if (icnt == 2'd3) begin
                            mem_ce_o <= 1'b0;
                        end else begin
                            mem_addr_o <= mem_addr_o + 32'd1;
                            icnt       <= icnt + 2'd1;
                        end
                    end
                    if (pipe[BYTE_LAT-1]) begin
                        inst_o[{rcnt, 3'b000} +: 8] <= mem_data_i;
                        rcnt <= rcnt + 2'd1;
                        if (rcnt == 2'd3) begin
                            state        <= DONE;
                            inst_valid_o <= 1'b1;
                            inst_pc_o    <= base;
                        end
                    end
                end
                DONE: begin
                    if (inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                        if (req_i) begin
                            state      <= FETCH;
                            base       <= pc_al;
                            mem_ce_o   <= 1'b1;
                            mem_addr_o <= pc_al;
                            icnt       <= '0;
                            rcnt       <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
